decode_stage: RTL and testbench

- Sits between the instruction queue (fetch side) and rename/dispatch in the out-of-order core.
- Pops one raw RV32I instruction per cycle and decodes it against the team's rv32i_op_b_t opcode enum into register indices, immediate, class flags and an illegal flag.
- Buffers decoded packets in a small output FIFO so rename back-pressure does not stall fetch.
- Supports a pipeline flush from the ROB on mispredict or exception.

---
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between the instruction queue and rename.
//   Each cycle it can accept one raw instruction from the IQ and decode it
//   combinationally. The decoded packet is written into a DEPTH-entry FIFO,
//   and rename reads the packet at the head of that FIFO.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 empties the buffer on the next edge; input is dropped
//   iq_valid/iq_ready     IQ handshake. iq_ready depends only on the count and flush.
//   iq_inst, iq_pc        raw instruction and its PC
//   dec_valid/dec_ready   rename handshake on the head packet
//   dec_pc .. dec_imm     decoded head packet (all zero while the buffer is empty)
//   dec_flags             {illegal, is_csr, is_jump, is_branch, is_store, is_load, writes_rd}
module decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        iq_valid,
  input  logic [31:0] iq_inst,
  input  logic [31:0] iq_pc,
  output logic        iq_ready,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_opcode,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [4:0]  dec_rd,
  output logic [31:0] dec_imm,
  output logic [6:0]  dec_flags
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011,
    OP_IMM   = 7'b0010011,
    OP_AUIPC = 7'b0010111,
    OP_STORE = 7'b0100011,
    OP_REG   = 7'b0110011,
    OP_LUI   = 7'b0110111,
    OP_BR    = 7'b1100011,
    OP_JALR  = 7'b1100111,
    OP_JAL   = 7'b1101111,
    OP_CSR   = 7'b1110011
  } rv32i_op_b_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  flags;
  } pkt_t;

  // ---------------- decode ----------------
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic        known, bad, use_rs1, use_rs2, use_rd;
  logic        jump, branch, load, store, csr, illegal;
  logic [31:0] imm;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  pkt_t        dec_pkt;

  assign op    = iq_inst[6:0];
  assign f3    = iq_inst[14:12];
  assign f7    = iq_inst[31:25];
  assign imm_i = {{20{iq_inst[31]}}, iq_inst[31:20]};

  always_comb begin
    known   = 1'b1;
    bad     = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    jump    = 1'b0;
    branch  = 1'b0;
    load    = 1'b0;
    store   = 1'b0;
    csr     = 1'b0;
    imm     = 32'h0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        use_rd = 1'b1;
        imm    = {iq_inst[31:12], 12'h000};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        jump   = 1'b1;
        imm    = {{12{iq_inst[31]}}, iq_inst[19:12], iq_inst[20], iq_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        jump    = 1'b1;
        imm     = imm_i;
        bad     = (f3 != 3'b000);
      end
      OP_BR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        branch  = 1'b1;
        imm     = {{20{iq_inst[31]}}, iq_inst[7], iq_inst[30:25], iq_inst[11:8], 1'b0};
        bad     = (f3[2:1] == 2'b01);                 // 010, 011
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        load    = 1'b1;
        imm     = imm_i;
        bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11); // 011, 110, 111
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        store   = 1'b1;
        imm     = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
        bad     = (f3 > 3'b010);
      end
      OP_IMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm     = imm_i;
        // Only the shifts carry a funct7. Only srai may use the alternate encoding.
        if (f3 == 3'b001)      bad = (f7 != 7'h00);
        else if (f3 == 3'b101) bad = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OP_REG: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        bad     = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OP_CSR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        csr     = 1'b1;
        imm     = imm_i;
      end
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || bad;
  assign rs1_idx = (use_rs1 && !illegal) ? iq_inst[19:15] : 5'd0;
  assign rs2_idx = (use_rs2 && !illegal) ? iq_inst[24:20] : 5'd0;
  assign rd_idx  = (use_rd  && !illegal) ? iq_inst[11:7]  : 5'd0;

  always_comb begin
    dec_pkt        = '0;
    dec_pkt.pc     = iq_pc;
    dec_pkt.opcode = op;
    dec_pkt.funct3 = f3;
    dec_pkt.funct7 = f7;
    dec_pkt.rs1    = rs1_idx;
    dec_pkt.rs2    = rs2_idx;
    dec_pkt.rd     = rd_idx;
    dec_pkt.imm    = imm;
    // A nonzero rd already implies that rd is used and the instruction is legal.
    dec_pkt.flags  = {illegal, csr & !illegal, jump & !illegal, branch & !illegal,
                      store & !illegal, load & !illegal, (rd_idx != 5'd0)};
  end

  // ---------------- packet buffer ----------------
  pkt_t          mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, pop;
  pkt_t          head_pkt;

  assign iq_ready  = (count != CW'(DEPTH)) && !flush;
  assign dec_valid = (count != '0);
  assign push      = iq_valid && iq_ready;
  assign pop       = dec_valid && dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The payload needs no reset. An entry is never read unless count says it is live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= dec_pkt;
  end

  assign head_pkt   = dec_valid ? mem[head] : '0;
  assign dec_pc     = head_pkt.pc;
  assign dec_opcode = head_pkt.opcode;
  assign dec_funct3 = head_pkt.funct3;
  assign dec_funct7 = head_pkt.funct7;
  assign dec_rs1    = head_pkt.rs1;
  assign dec_rs2    = head_pkt.rs2;
  assign dec_rd     = head_pkt.rd;
  assign dec_imm    = head_pkt.imm;
  assign dec_flags  = head_pkt.flags;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized self-checking bench for decode_stage. A queue
// model of the buffer holds packets that are decoded directly from the ISA rules.
module tb_decode_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        iq_valid = 1'b0;
  logic [31:0] iq_inst = '0;
  logic [31:0] iq_pc = '0;
  logic        iq_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  logic [6:0]  dec_flags;

  decode_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_flags(dec_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [6:0]  flags;
  } exp_t;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ISA-level reference decode.
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67,
                         BR = 7'h63, LOAD = 7'h03, STORE = 7'h23, IMM = 7'h13,
                         REG = 7'h33, CSR = 7'h73;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic il;
    logic [4:0] rd;
    il = !(op inside {LUI, AUIPC, JAL, JALR, BR, LOAD, STORE, IMM, REG, CSR})
      || (op == BR    && f3 inside {3'd2, 3'd3})
      || (op == LOAD  && f3 inside {3'd3, 3'd6, 3'd7})
      || (op == STORE && f3 > 3'd2)
      || (op == JALR  && f3 != 3'd0)
      || (op == REG   && !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5})))
      || (op == IMM   && f3 inside {3'd1, 3'd5} && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)));
    e.pc = pc; e.opcode = op; e.funct3 = f3; e.funct7 = f7;
    if (op inside {LOAD, IMM, JALR, CSR})  e.imm = 32'($signed(i[31:20]));
    else if (op == STORE) e.imm = 32'($signed({i[31:25], i[11:7]}));
    else if (op == BR)    e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    else if (op inside {LUI, AUIPC}) e.imm = i & 32'hFFFFF000;
    else if (op == JAL)   e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    else                  e.imm = 32'h0;
    e.rs1 = (!il && op inside {JALR, BR, LOAD, STORE, IMM, REG, CSR}) ? i[19:15] : 5'd0;
    e.rs2 = (!il && op inside {BR, STORE, REG}) ? i[24:20] : 5'd0;
    rd    = (!il && op inside {LUI, AUIPC, JAL, JALR, LOAD, IMM, REG, CSR}) ? i[11:7] : 5'd0;
    e.rd  = rd;
    e.flags = il ? 7'b1000000 :
              {1'b0, op == CSR, op inside {JAL, JALR}, op == BR, op == STORE, op == LOAD, rd != 5'd0};
    return e;
  endfunction

  // Model update on the active edge.
  bit m_rdy, m_pop;
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) q.delete();
      else begin
        m_rdy = (q.size() != DEPTH);
        m_pop = (q.size() != 0) && dec_ready;
        if (m_pop) void'(q.pop_front());
        if (iq_valid && m_rdy) q.push_back(model(iq_inst, iq_pc));
      end
    end
  end
  always @(negedge rst_n) q.delete();

  // Compare on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("iq_ready", iq_ready, (q.size() != DEPTH) && !flush);
      chk("dec_valid", dec_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("pc", dec_pc, q[0].pc);
        chk("opcode", dec_opcode, q[0].opcode);
        chk("funct3", dec_funct3, q[0].funct3);
        chk("funct7", dec_funct7, q[0].funct7);
        chk("regs", {dec_rs1, dec_rs2, dec_rd}, {q[0].rs1, q[0].rs2, q[0].rd});
        chk("imm", dec_imm, q[0].imm);
        chk("flags", dec_flags, q[0].flags);
      end else begin
        chk("empty_zero", {dec_pc, dec_opcode, dec_funct3, dec_funct7, dec_rs1, dec_rs2,
                           dec_rd, dec_imm[15:0]} | 64'(|{dec_imm, dec_flags}), 64'h0);
      end
    end
  end

  // Presents one instruction while the buffer is empty. Returns at the
  // falling edge after the accepting edge.
  task automatic one(input logic [31:0] inst, input logic [31:0] pc);
    dec_ready = 1'b0;
    iq_valid = 1'b1; iq_inst = inst; iq_pc = pc;
    @(posedge clk); #1;
    iq_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    dec_ready = 1'b1;
    while (dec_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (dec_valid) chk("drain_timeout", 1, 0);
    dec_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    logic [6:0] op;
    case ($urandom_range(0, 11))
      0: op = LUI;   1: op = AUIPC; 2: op = JAL;  3: op = JALR;
      4: op = BR;    5: op = LOAD;  6: op = STORE; 7: op = IMM;
      8: op = REG;   9: op = CSR;   10: op = 7'h0F;
      default: op = r[6:0];
    endcase
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    if ($urandom_range(0, 3) == 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return {r[31:7], op};
  endfunction

  exp_t e;
  int acc, pops, n;
  logic [31:0] pc, first_pc;

  initial begin
    // The model decode is pinned to values worked out by hand.
    e = model(32'hFE208CE3, 0);
    chk("m_beq", {e.rs1, e.rs2, e.rd, e.imm, e.flags}, {5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 7'b0001000});
    e = model(32'h0050A623, 0);
    chk("m_sw", {e.rs1, e.rs2, e.rd, e.imm, e.flags}, {5'd1, 5'd5, 5'd0, 32'h0000000C, 7'b0000100});
    e = model(32'h12345137, 0);
    chk("m_lui", {e.rs1, e.rs2, e.rd, e.imm, e.flags}, {5'd0, 5'd0, 5'd2, 32'h12345000, 7'b0000001});
    e = model(32'h40001033, 0);
    chk("m_ill", {e.rs1, e.rs2, e.rd, e.flags}, {5'd0, 5'd0, 5'd0, 7'b1000000});

    repeat (2) @(posedge clk);
    #1 armed = 1'b1;
    @(negedge clk);
    chk("rst_valid", dec_valid, 0);
    chk("rst_ready", iq_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode cases
    one(32'h00500093, 32'h60000000);
    chk("addi_valid", dec_valid, 1);
    chk("addi_pc", dec_pc, 32'h60000000);
    chk("addi_regs", {dec_rs1, dec_rs2, dec_rd}, {5'd0, 5'd0, 5'd1});
    chk("addi_imm", dec_imm, 32'h5);
    chk("addi_flags", dec_flags, 7'b0000001);
    drain();
    one(32'hFE208CE3, 32'h60000004);
    chk("beq_regs", {dec_rs1, dec_rs2, dec_rd}, {5'd1, 5'd2, 5'd0});
    chk("beq_imm", dec_imm, 32'hFFFFFFF8);
    chk("beq_flags", dec_flags, 7'b0001000);
    drain();
    one(32'h0050A623, 32'h60000008);
    chk("sw_fields", {dec_rs2, dec_rd, dec_imm}, {5'd5, 5'd0, 32'h0000000C});
    drain();
    one(32'h12345137, 32'h6000000C);
    chk("lui_fields", {dec_rs1, dec_rd, dec_imm}, {5'd0, 5'd2, 32'h12345000});
    drain();
    one(32'h00000000, 32'h60000010);
    chk("zero_flags", {dec_flags, dec_rs1, dec_rs2, dec_rd}, {7'b1000000, 15'd0});
    drain();
    one(32'h40001033, 32'h60000014);
    chk("sll_alt_flags", {dec_flags, dec_rs1, dec_rs2, dec_rd}, {7'b1000000, 15'd0});
    drain();

    // Hold rename off with the IQ always valid.
    pc = 32'h70000000; first_pc = pc;
    dec_ready = 1'b0; iq_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      iq_inst = rand_inst(); iq_pc = pc;
      @(negedge clk);
      if (iq_ready) pc = pc + 4;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_ready", iq_ready, 0);
    chk("hold_head", dec_pc, first_pc);
    @(posedge clk); #1;
    iq_valid = 1'b0; dec_ready = 1'b1; pops = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dec_valid) pops++;
      @(posedge clk); #1;
    end
    chk("hold_drain_pops", pops, 2);

    // Back-to-back streaming of ten instructions
    acc = 0; n = 0; dec_ready = 1'b1; iq_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      iq_inst = rand_inst(); iq_pc = pc;
      @(negedge clk);
      if (iq_ready) begin acc++; pc = pc + 4; end
      @(posedge clk); #1;
    end
    iq_valid = 1'b0;
    chk("stream_accepts", acc, 10);
    drain();

    // Flush while the buffer is full, with an instruction offered in the flush cycle
    one(rand_inst(), 32'h80000000);
    iq_valid = 1'b1; iq_inst = rand_inst(); iq_pc = 32'h80000004;
    @(posedge clk); #1;
    iq_inst = 32'h00100093; iq_pc = 32'hDEAD0000; flush = 1'b1;
    @(negedge clk);
    chk("full_before_flush", dec_valid, 1);
    chk("flush_ready", iq_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; iq_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", dec_valid, 0);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      iq_valid  = ($urandom_range(0, 3) != 0);
      dec_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      iq_inst   = rand_inst();
      iq_pc     = $urandom & 32'hFFFFFFFC;
      @(posedge clk); #1;
    end
    flush = 1'b0; iq_valid = 1'b0;

    // Reset in the middle of traffic
    one(rand_inst(), 32'h90000000);
    chk("pre_reset_valid", dec_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk("reset_drop", dec_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
